pipelined_addsub: RTL
=====================

Name: pipelined_addsub

Overview:
- Parametrised, pipelined WIDTH-bit adder/subtractor, built as STAGES chained ripple-carry chunks.
- Carry is registered between chunks, so a new operation can be accepted every cycle.
- Valid/ready handshakes on input and output, with full backpressure.
- Sits between operand producers and a result consumer in the datapath. Replaces single-cycle combinational full-adder chains where WIDTH makes ripple timing unacceptable.

Parameters:
WIDTH, 32, operand and result width in bits; must be a multiple of STAGES.
STAGES, 4, number of pipeline stages; each stage adds CHUNK = WIDTH/STAGES bits; 1 <= STAGES <= WIDTH.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  operands a/b/cin/sub valid this cycle
in_ready  output  1  block accepts operands this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in (add) / borrow-in (sub)
sub  input  1  0: a+b+cin; 1: a-b-cin
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result, modulo 2^WIDTH
cout  output  1  raw carry out of MSB (in sub mode, 1 = no borrow)
ovf  output  1  two's-complement signed overflow

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Effective operands:
  - b_eff = sub ? ~b : b.
  - c0 = sub ? ~cin : cin.
  - Result = a + b_eff + c0 in all modes.
  - sub=1, cin=0 gives a-b; sub=1, cin=1 gives a-b-1.
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Pipeline advance: adv = !out_valid || out_ready. All stage registers load only when adv=1; otherwise every stage holds.
- in_ready = adv. This is combinational from out_ready and out_valid, with no path from in_valid.
- Stage k (0..STAGES-1) datapath:
  - Adds chunk k of a and b_eff plus the carry registered from stage k-1 (stage 0 uses c0).
  - Registers the CHUNK sum bits, the chunk carry-out, and the per-stage valid.
  - Operand chunks above k, and sum chunks below k, are carried forward in skew/deskew registers.
- Latency: exactly STAGES cycles from input transfer to out_valid when not stalled. Throughput: 1 result per cycle.
- Bubbles: a stage whose valid=0 still shifts on adv. Bubbles are not collapsed; global stall only.
- ovf = carry into MSB XOR carry out of MSB, computed inside the last stage and registered with sum.
- Output stability: sum, cout and ovf are registered; they are held stable while out_valid && !out_ready.
- Reset:
  - Clears all per-stage valid bits, so out_valid=0.
  - Clears sum, cout, ovf and all data registers to 0.
  - in_ready=1 during the first cycle after reset deasserts.
- Reset mid-operation: all in-flight results are discarded and none are emitted afterward.
- Reset takes priority over a simultaneous input transfer; an operand presented in the reset cycle is dropped.
- Simultaneous input and output transfer in the same cycle is legal; the pipeline shifts by one and stays full.
- Wrap-around: sum wraps modulo 2^WIDTH; cout and ovf report it.
- STAGES=1: the block degenerates to one registered WIDTH-bit adder with latency 1.
- No combinational path from a, b, cin or sub to any output.

Decomposition:
- Shared package: CHUNK localparam derivation (WIDTH/STAGES); a compile-time check that WIDTH % STAGES == 0; operand/result struct typedef (sum, cout, ovf).
- One sub-module: addsub_chunk. It is a CHUNK-bit ripple adder built from per-bit full-adder cells, with inputs chunk_a, chunk_b, c_in and outputs chunk_sum, c_out, c_msb_in (carry into the top bit, for ovf).
- The top level instantiates STAGES addsub_chunk instances plus the valid/skew registers and handshake logic.

Test Plan (WIDTH=8, STAGES=4 unless noted):
- Basic add: a=0x3C, b=0x1F, cin=0, sub=0, out_ready=1 -> 4 cycles later out_valid=1, sum=0x5B, cout=0, ovf=0.
- Wrap and overflow: a=0x7F, b=0x01, sub=0 -> sum=0x80, cout=0, ovf=1. a=0xFF, b=0x01, cin=1 -> sum=0x01, cout=1, ovf=0.
- Subtract: a=0x05, b=0x07, sub=1, cin=0 -> sum=0xFE, cout=0 (borrow), ovf=0. a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1.
- Backpressure: stream 8 back-to-back operations, then hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 while stalled, out_valid held, sum stable. All 8 results appear in order with none lost or duplicated; throughput returns to 1/cycle after release.
- Reset mid-stream: 3 operations in flight, assert reset for 1 cycle -> out_valid=0, sum=0, cout=0, ovf=0 next cycle, and none of the 3 results ever appear. in_ready=1 after reset deasserts.
- Randomised sweep: STAGES in {1, 2, 8} with WIDTH=8, and WIDTH=32/STAGES=4. Random valid/ready and random a/b/cin/sub -> every result matches the reference model (a + b_eff + c0) for sum, cout and ovf, in order.

Source files
------------

// File: rtl/pipelined_addsub_pkg.sv
// pipelined_addsub_pkg: sizing helpers and registered result flags for pipelined_addsub
package pipelined_addsub_pkg;
  function automatic int chunk_of(input int width, input int stages);
    return width / stages;
  endfunction
  function automatic bit cfg_ok(input int width, input int stages);
    return stages >= 1 && stages <= width && width % stages == 0;
  endfunction
  typedef struct packed {
    logic cout;
    logic ovf;
  } res_flags_t;
endpackage

// File: rtl/pipelined_addsub_chunk.sv
// addsub_chunk: CHUNK-bit ripple adder of full-adder cells, exposing the carry into its top bit
module addsub_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] chunk_a,
  input  logic [CHUNK-1:0] chunk_b,
  input  logic             c_in,
  output logic [CHUNK-1:0] chunk_sum,
  output logic             c_out,
  output logic             c_msb_in
);
  for (genvar i = 0; i < CHUNK; i++) begin : fa
    logic w_ci, w_co;
    if (i == 0) begin : g_lsb
      assign w_ci = c_in;
    end else begin : g_bit
      assign w_ci = fa[i-1].w_co;
    end
    assign chunk_sum[i] = chunk_a[i] ^ chunk_b[i] ^ w_ci;
    assign w_co = (chunk_a[i] & chunk_b[i]) | (w_ci & (chunk_a[i] ^ chunk_b[i]));
  end
  assign c_out = fa[CHUNK-1].w_co;
  assign c_msb_in = fa[CHUNK-1].w_ci;
endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: STAGES-deep chunked add/sub with registered inter-chunk carry and valid/ready flow
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CHUNK = chunk_of(WIDTH, STAGES);
  if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_addsub: need 1 <= STAGES <= WIDTH and WIDTH %% STAGES == 0");
  end
  logic             w_adv, w_c0;
  logic [WIDTH-1:0] w_beff;
  assign w_adv = !out_valid || out_ready;
  assign in_ready = w_adv;
  assign w_beff = sub ? ~b : b;
  assign w_c0 = sub ? ~cin : cin;
  // r_x holds finished sum chunks below k+1 and untouched A chunks above; r_y holds remaining B chunks, LSB-aligned
  for (genvar k = 0; k < STAGES; k++) begin : stg
    logic [WIDTH-1:0]         w_xi, w_xo, r_x;
    logic [WIDTH-k*CHUNK-1:0] w_yi;
    logic [CHUNK-1:0]         w_s;
    logic                     w_ci, w_vi, w_co, w_cm, r_v;
    if (k == 0) begin : g_first
      assign w_xi = a;
      assign w_yi = w_beff;
      assign w_ci = w_c0;
      assign w_vi = in_valid;
    end else begin : g_next
      assign w_xi = stg[k-1].r_x;
      assign w_yi = stg[k-1].g_y.r_y;
      assign w_ci = stg[k-1].g_y.r_c;
      assign w_vi = stg[k-1].r_v;
    end
    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .chunk_a  (w_xi[k*CHUNK +: CHUNK]),
      .chunk_b  (w_yi[CHUNK-1:0]),
      .c_in     (w_ci),
      .chunk_sum(w_s),
      .c_out    (w_co),
      .c_msb_in (w_cm)
    );
    always_comb begin
      w_xo = w_xi;
      w_xo[k*CHUNK +: CHUNK] = w_s;
    end
    always_ff @(posedge clk) begin
      if (reset) begin
        r_x <= '0;
        r_v <= 1'b0;
      end else if (w_adv) begin
        r_x <= w_xo;
        r_v <= w_vi;
      end
    end
    if (k < STAGES - 1) begin : g_y
      logic [WIDTH-(k+1)*CHUNK-1:0] r_y;
      logic                         r_c, w_unused_cm;
      assign w_unused_cm = w_cm;
      always_ff @(posedge clk) begin
        if (reset) begin
          r_y <= '0;
          r_c <= 1'b0;
        end else if (w_adv) begin
          r_y <= w_yi[WIDTH-k*CHUNK-1:CHUNK];
          r_c <= w_co;
        end
      end
    end else begin : g_last
      res_flags_t r_f;
      always_ff @(posedge clk) begin
        if (reset) r_f <= '0;
        else if (w_adv) r_f <= '{cout: w_co, ovf: w_co ^ w_cm};
      end
    end
  end
  assign out_valid = stg[STAGES-1].r_v;
  assign sum = stg[STAGES-1].r_x;
  assign cout = stg[STAGES-1].g_last.r_f.cout;
  assign ovf = stg[STAGES-1].g_last.r_f.ovf;
endmodule
